// File: rtl/hamming_rx_ctrl.sv
// Hamming(7,4)+parity receive controller: decodes codewords, packs nibble
// pairs into bytes, keeps saturating BER counters. Option: HAMRX_DROP_UNCORR_EN
module hamming_decoder (
    input  logic [6:0] in,
    input  logic       in_parity,
    output logic [3:0] data,
    output logic       error_1bit,
    output logic       error_2bit
);
    logic [2:0] w_syn;
    logic       w_par_err;
    logic [7:0] w_mask;
    logic [7:0] w_fix;

    assign w_syn[0]   = in[0] ^ in[2] ^ in[4] ^ in[6];
    assign w_syn[1]   = in[1] ^ in[2] ^ in[5] ^ in[6];
    assign w_syn[2]   = in[3] ^ in[4] ^ in[5] ^ in[6];
    assign w_par_err  = in_parity ^ (^in);
    assign error_1bit = |w_syn;
    // Nonzero syndrome with consistent overall parity means two flips.
    assign error_2bit = error_1bit & ~w_par_err;

    // Flip the bit at the syndrome position; bit index equals code position.
    always_comb begin
        w_mask = 8'd1 << w_syn;
        w_fix  = {in, 1'b0};
        if (error_1bit & w_par_err)
            w_fix = w_fix ^ w_mask;
    end

    assign data = {w_fix[7], w_fix[6], w_fix[5], w_fix[3]};
endmodule

module hamming_rx_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       cw_in,
    input  logic             cw_valid,
    output logic             cw_ready,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             byte_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] nib_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);
    localparam logic [1:0] S_LO  = 2'd0;
    localparam logic [1:0] S_HI  = 2'd1;
    localparam logic [1:0] S_OUT = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       r_state;
    logic [7:0]       r_byte;
    logic             r_valid;
    logic             r_lo_err;
    logic [CNT_W-1:0] r_nib;
    logic [CNT_W-1:0] r_corr;
    logic [CNT_W-1:0] r_unc;
    logic [3:0]       w_data;
    logic             w_e1;
    logic             w_e2;
    logic             w_acc;
    logic             w_corr;

    hamming_decoder u_dec (
        .in         (cw_in[6:0]),
        .in_parity  (cw_in[7]),
        .data       (w_data),
        .error_1bit (w_e1),
        .error_2bit (w_e2)
    );

    assign cw_ready   = (r_state != S_OUT) | byte_ready;
    assign w_acc      = cw_valid & cw_ready;
    assign w_corr     = w_e1 & ~w_e2;
    assign byte_out   = r_byte;
    assign byte_valid = r_valid;
    assign nib_cnt    = r_nib;
    assign corr_cnt   = r_corr;
    assign uncorr_cnt = r_unc;

`ifdef HAMRX_DROP_UNCORR_EN
    assign byte_err = 1'b0;
`else
    logic r_err;
    assign byte_err = r_err;
`endif

    // Pairing FSM and byte holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_LO;
            r_byte   <= 8'h00;
            r_valid  <= 1'b0;
            r_lo_err <= 1'b0;
`ifndef HAMRX_DROP_UNCORR_EN
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_LO: begin
                    if (w_acc) begin
                        r_byte[3:0] <= w_data;
                        r_lo_err    <= w_e2;
                        r_state     <= S_HI;
                    end
                end
                S_HI: begin
                    if (w_acc) begin
                        r_byte[7:4] <= w_data;
`ifdef HAMRX_DROP_UNCORR_EN
                        if (r_lo_err | w_e2) begin
                            r_state <= S_LO;
                        end else begin
                            r_valid <= 1'b1;
                            r_state <= S_OUT;
                        end
`else
                        r_err   <= r_lo_err | w_e2;
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
`endif
                    end
                end
                S_OUT: begin
                    if (byte_ready) begin
                        r_valid <= 1'b0;
                        if (w_acc) begin
                            r_byte[3:0] <= w_data;
                            r_lo_err    <= w_e2;
                            r_state     <= S_HI;
                        end else begin
                            r_state <= S_LO;
                        end
                    end
                end
                default: r_state <= S_LO;
            endcase
        end
    end

    // Saturating statistics counters; clear beats a simultaneous accept.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            r_nib  <= '0;
            r_corr <= '0;
            r_unc  <= '0;
        end else if (w_acc) begin
            if (r_nib != CNT_MAX)
                r_nib <= r_nib + 1'b1;
            if (w_corr && r_corr != CNT_MAX)
                r_corr <= r_corr + 1'b1;
            if (w_e2 && r_unc != CNT_MAX)
                r_unc <= r_unc + 1'b1;
        end
    end
endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Self-checking bench for hamming_rx_ctrl: directed plan steps followed by
// randomized traffic against a transaction-level reference model.
module tb_hamming_rx_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  cw_in = 8'h00;
    logic        cw_valid = 1'b0;
    logic        byte_ready = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        cw_ready, cw_ready2;
    logic [7:0]  byte_out, byte_out2;
    logic        byte_valid, byte_valid2;
    logic        byte_err, byte_err2;
    logic [15:0] nib_cnt, corr_cnt, uncorr_cnt;
    logic [1:0]  nib2, corr2, unc2;

    int checks = 0;
    int errors = 0;

    // model state
    bit         m_half, m_held, m_lo_err, m_err;
    logic [3:0] m_lo;
    logic [7:0] m_byte;
    int         m_nib, m_corr, m_unc, s_nib, s_corr, s_unc;

    always #5 clk = ~clk;

    hamming_rx_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cw_in(cw_in), .cw_valid(cw_valid),
        .cw_ready(cw_ready), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .byte_err(byte_err), .cnt_clr(cnt_clr),
        .nib_cnt(nib_cnt), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    hamming_rx_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cw_in(cw_in), .cw_valid(cw_valid),
        .cw_ready(cw_ready2), .byte_out(byte_out2), .byte_valid(byte_valid2),
        .byte_ready(byte_ready), .byte_err(byte_err2), .cnt_clr(cnt_clr),
        .nib_cnt(nib2), .corr_cnt(corr2), .uncorr_cnt(unc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [6:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        return {^c, c};
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    task automatic model_reset();
        m_half = 0; m_held = 0; m_lo_err = 0; m_err = 0;
        m_lo = 4'h0; m_byte = 8'h00;
        m_nib = 0; m_corr = 0; m_unc = 0;
        s_nib = 0; s_corr = 0; s_unc = 0;
    endtask

    task automatic check_outs();
        chk("byte_valid", {31'b0, byte_valid}, {31'b0, m_held});
        if (m_held) begin
            if (!m_err)
                chk("byte_out", {24'b0, byte_out}, {24'b0, m_byte});
`ifdef HAMRX_DROP_UNCORR_EN
            chk("byte_err", {31'b0, byte_err}, 32'd0);
`else
            chk("byte_err", {31'b0, byte_err}, {31'b0, m_err});
`endif
        end
        chk("nib_cnt", {16'b0, nib_cnt}, m_nib);
        chk("corr_cnt", {16'b0, corr_cnt}, m_corr);
        chk("uncorr_cnt", {16'b0, uncorr_cnt}, m_unc);
        chk("nib_cnt_w2", {30'b0, nib2}, s_nib);
        chk("corr_cnt_w2", {30'b0, corr2}, s_corr);
        chk("uncorr_cnt_w2", {30'b0, unc2}, s_unc);
    endtask

    task automatic do_reset();
        reset = 1'b1; cw_valid = 1'b0; cnt_clr = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("rst_cw_ready", {31'b0, cw_ready}, 32'd1);
        chk("rst_byte_out", {24'b0, byte_out}, 32'd0);
        chk("rst_byte_err", {31'b0, byte_err}, 32'd0);
        check_outs();
    endtask

    // cls: 0 clean, 1 corrected, 2 uncorrectable
    task automatic step(input logic v, input logic [7:0] cw,
                        input logic [3:0] nib, input int cls,
                        input logic rdy, input logic clr);
        bit er, acc, unc;
        cw_valid = v; cw_in = cw; byte_ready = rdy; cnt_clr = clr;
        er = !m_held || rdy;
        @(negedge clk);
        chk("cw_ready", {31'b0, cw_ready}, {31'b0, er});
        @(posedge clk); #1;
        acc = v && er;
        unc = (cls == 2);
        if (m_held && rdy) m_held = 0;
        if (acc) begin
            if (!m_half) begin
                m_lo = nib; m_lo_err = unc; m_half = 1;
            end else begin
                m_half = 0;
                m_byte = {nib, m_lo};
                m_err = m_lo_err || unc;
`ifdef HAMRX_DROP_UNCORR_EN
                m_held = !m_err;
`else
                m_held = 1;
`endif
            end
        end
        if (clr) begin
            m_nib = 0; m_corr = 0; m_unc = 0;
            s_nib = 0; s_corr = 0; s_unc = 0;
        end else if (acc) begin
            m_nib = sat(m_nib, 65535);
            s_nib = sat(s_nib, 3);
            if (cls == 1) begin
                m_corr = sat(m_corr, 65535);
                s_corr = sat(s_corr, 3);
            end
            if (cls == 2) begin
                m_unc = sat(m_unc, 65535);
                s_unc = sat(s_unc, 3);
            end
        end
        check_outs();
    endtask

    initial begin
        logic [3:0] d;
        logic [7:0] cw;
        int k, b1, b2, cls;
        logic [7:0] held;

        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Clean pair -> A5
        step(1, 8'h2D, 4'h5, 0, 1, 0);
        step(1, 8'hD2, 4'hA, 0, 1, 0);
        chk("a5_out", {24'b0, byte_out}, 32'hA5);
        chk("a5_nib", {16'b0, nib_cnt}, 32'd2);
        step(0, 8'h00, 4'h0, 0, 1, 0);
        chk("a5_one_cycle", {31'b0, byte_valid}, 32'd0);

        // Single-bit error corrected
        step(1, 8'h2C, 4'h5, 1, 1, 0);
        step(1, 8'hD2, 4'hA, 0, 1, 0);
        chk("corr_out", {24'b0, byte_out}, 32'hA5);
        chk("corr_cnt1", {16'b0, corr_cnt}, 32'd1);

        // Double-bit error
        step(1, 8'h2E, 4'h5, 2, 1, 0);
        step(1, 8'hD2, 4'hA, 0, 1, 0);
        chk("unc_cnt1", {16'b0, uncorr_cnt}, 32'd1);
        step(0, 8'h00, 4'h0, 0, 1, 0);

        // Backpressure
        step(1, 8'h2D, 4'h5, 0, 0, 0);
        step(1, 8'hD2, 4'hA, 0, 0, 0);
        held = byte_out;
        step(1, enc(4'h3), 4'h3, 0, 0, 0);
        step(1, enc(4'h3), 4'h3, 0, 0, 0);
        chk("bp_stable", {24'b0, byte_out}, {24'b0, held});
        step(1, enc(4'h3), 4'h3, 0, 1, 0);
        step(1, enc(4'hC), 4'hC, 0, 1, 0);
        chk("bp_next", {24'b0, byte_out}, 32'hC3);

        // Saturation with narrow counters, then clear with accept
        step(0, 8'h00, 4'h0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            d = 4'(i + 1);
            step(1, enc(d), d, 0, 1, 0);
        end
        chk("sat_nib_w2", {30'b0, nib2}, 32'd3);
        step(1, enc(4'h9), 4'h9, 0, 1, 1);
        chk("clr_acc_nib", {16'b0, nib_cnt}, 32'd0);

        // Reset mid-pair
        do_reset();
        step(1, 8'h2D, 4'h5, 0, 1, 0);
        do_reset();
        step(1, 8'hD2, 4'hA, 0, 1, 0);
        step(1, 8'h2D, 4'h5, 0, 1, 0);
        chk("rst_mid_out", {24'b0, byte_out}, 32'h5A);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            d = 4'($urandom_range(0, 15));
            cw = enc(d);
            k = $urandom_range(0, 9);
            k = (k < 6) ? 0 : (k < 9) ? 1 : 2;
            b1 = $urandom_range(0, 7);
            b2 = (b1 + $urandom_range(1, 7)) % 8;
            cls = 0;
            if (k >= 1) begin
                cw[b1] = ~cw[b1];
                cls = (b1 == 7) ? 0 : 1;
            end
            if (k == 2) begin
                cw[b2] = ~cw[b2];
                cls = 2;
            end
            step(1'($urandom_range(0, 3) != 0), cw, d, cls,
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 63) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
